// File: rtl/online_operand_append.sv
// -----------------------------------------------------------------------------
// online_operand_append
//
// Digit-serial on-the-fly append register feeding the signed-digit
// vector-select stage of the online multiplier.
//
// One signed operand digit arrives per cycle, most significant first. Each
// accepted digit x_j is appended at weight 2^-j. This builds the partial
// operand X[j] = X[j-1] + x_j*2^-j as a redundant pair of vectors whose value
// is vec_out_plus - vec_out_minus. Each position is written at most once, so
// at most one of the two bits is ever set per position. No carry is needed.
//
// Digit code: 2'b10 = +1, 2'b01 = -1, 2'b00 = 0, 2'b11 = illegal.
//
// Ports:
//   clk             in   rising-edge clock
//   asyn_reset      in   asynchronous reset, active low
//   enable          in   clock enable; low freezes every register
//   start           in   begin a new operand (clears vectors, pos, err)
//   digit_in[1:0]   in   operand digit
//   digit_valid     in   digit_in is valid this cycle
//   vec_out_plus    out  positive-weight bits of X[j]
//   vec_out_minus   out  negative-weight bits of X[j]
//   digit_fwd[1:0]  out  last accepted digit (illegal code forwarded as 0)
//   digit_fwd_valid out  one-cycle pulse: digit_fwd was updated
//   pos[CNT_W-1:0]  out  number of digits accepted so far
//   busy            out  operand is being accumulated
//   done            out  one-cycle pulse after the final digit is appended
//   err             out  sticky: an illegal digit code was accepted
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module online_operand_append #(
  parameter int Num_bits = 4,
  parameter int CNT_W    = 3
) (
  input  logic                clk,
  input  logic                asyn_reset,
  input  logic                enable,
  input  logic                start,
  input  logic [1:0]          digit_in,
  input  logic                digit_valid,
  output logic [Num_bits-1:0] vec_out_plus,
  output logic [Num_bits-1:0] vec_out_minus,
  output logic [1:0]          digit_fwd,
  output logic                digit_fwd_valid,
  output logic [CNT_W-1:0]    pos,
  output logic                busy,
  output logic                done,
  output logic                err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0]       DIG_POS  = 2'b10;
  localparam logic [1:0]       DIG_NEG  = 2'b01;
  localparam logic [1:0]       DIG_BAD  = 2'b11;
  localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(Num_bits - 1);

  // One-hot mask of the bit written by the digit at position p.
  // Digit 0 lands in the MSB.
  function automatic logic [Num_bits-1:0] pos_mask(input logic [CNT_W-1:0] p);
    logic [Num_bits-1:0] m;
    m = '0;
    for (int i = 0; i < Num_bits; i++) begin
      if (p == CNT_W'(Num_bits - 1 - i)) m[i] = 1'b1;
    end
    return m;
  endfunction

  // The illegal code is forwarded downstream as a zero digit.
  function automatic logic [1:0] legal_digit(input logic [1:0] d);
    return (d == DIG_BAD) ? 2'b00 : d;
  endfunction

  state_t              state, state_nxt;
  logic [Num_bits-1:0] plus_nxt, minus_nxt;
  logic [1:0]          fwd_nxt;
  logic                fwd_vld_nxt;
  logic [CNT_W-1:0]    pos_nxt;
  logic                done_nxt;
  logic                err_nxt;
  logic                clear;
  logic                accept;
  logic [Num_bits-1:0] mask;

  assign busy = (state == ACCUM);
  assign mask = pos_mask(pos);

  // A start in any state clears the operand.
  // A start in ACCUM also drops any simultaneous digit.
  always_comb begin
    state_nxt = state;
    clear     = 1'b0;
    accept    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          clear     = 1'b1;
          state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        if (start) begin
          clear = 1'b1;
        end else if (digit_valid) begin
          accept = 1'b1;
          if (pos == LAST_POS) state_nxt = DONE;
        end
      end
      DONE: begin
        if (start) begin
          clear     = 1'b1;
          state_nxt = ACCUM;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath next values.
  // done and digit_fwd_valid default low, so they only pulse for one cycle.
  always_comb begin
    plus_nxt    = vec_out_plus;
    minus_nxt   = vec_out_minus;
    fwd_nxt     = digit_fwd;
    fwd_vld_nxt = 1'b0;
    pos_nxt     = pos;
    done_nxt    = 1'b0;
    err_nxt     = err;
    if (clear) begin
      plus_nxt  = '0;
      minus_nxt = '0;
      pos_nxt   = '0;
      err_nxt   = 1'b0;
    end else if (accept) begin
      unique case (digit_in)
        DIG_POS: plus_nxt  = vec_out_plus  | mask;
        DIG_NEG: minus_nxt = vec_out_minus | mask;
        DIG_BAD: err_nxt   = 1'b1;
        default: ;
      endcase
      fwd_nxt     = legal_digit(digit_in);
      fwd_vld_nxt = 1'b1;
      pos_nxt     = pos + CNT_W'(1);
      done_nxt    = (pos == LAST_POS);
    end
  end

  // ---- register stage: state and append vectors (1-cycle latency) ----
  always_ff @(posedge clk or negedge asyn_reset) begin
    if (!asyn_reset) begin
      state           <= IDLE;
      vec_out_plus    <= '0;
      vec_out_minus   <= '0;
      digit_fwd       <= 2'b00;
      digit_fwd_valid <= 1'b0;
      pos             <= '0;
      done            <= 1'b0;
      err             <= 1'b0;
    end else if (enable) begin
      state           <= state_nxt;
      vec_out_plus    <= plus_nxt;
      vec_out_minus   <= minus_nxt;
      digit_fwd       <= fwd_nxt;
      digit_fwd_valid <= fwd_vld_nxt;
      pos             <= pos_nxt;
      done            <= done_nxt;
      err             <= err_nxt;
    end
  end

endmodule
